// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer, the PC controller and CP0:
// FSM state encoding, default vector layout and the vector address helper.
package int_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_SERVICE = 2'd2
  } seq_state_e;

  localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0800;
  localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'h0000_0010;
  localparam int          IRQ_ID_W           = 3;

  // Vector address in 32 bits; overflow wraps.
  function automatic logic [31:0] vec_addr(input logic [31:0]         base,
                                           input logic [31:0]         stride,
                                           input logic [IRQ_ID_W-1:0] id);
    logic [31:0] offset;
    offset = 32'(id) * stride;
    return base + offset;
  endfunction

endpackage

// File: rtl/int_sequencer_prio_enc.sv
// Lowest-set-bit encoder: index 0 has the highest priority.
module irq_prio_enc
  import int_sequencer_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic [N_IRQ-1:0]    req_i,
  output logic [IRQ_ID_W-1:0] idx_o,
  output logic                valid_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer: captures irq edges, waits for a safe pipeline point,
// pulses LD_INTS with the vector, and pulses INTS_end when ERET executes.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int          N_IRQ      = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_IRQ-1:0]    irq,
  input  logic                mask_we,
  input  logic [N_IRQ-1:0]    mask_wdata,
  input  logic                safe_point,
  input  logic [31:0]         epc_src,
  input  logic                eret_ex,
  output logic                LD_INTS,
  output logic [31:0]         INTS_PC,
  output logic                INTS_end,
  output logic [31:0]         EPC,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic                in_service
);

  localparam logic [N_IRQ-1:0] ONE = N_IRQ'(1);

  seq_state_e          state_q, state_d;
  logic [N_IRQ-1:0]    irq_q;
  logic [N_IRQ-1:0]    pending_q, pending_d;
  logic [N_IRQ-1:0]    mask_q;
  logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;
  logic [31:0]         epc_q, epc_d;
  logic                ld_q, ld_d;
  logic                end_q, end_d;

  logic [N_IRQ-1:0]    irq_edge;
  logic [N_IRQ-1:0]    enabled;
  logic [N_IRQ-1:0]    sel;
  logic [N_IRQ-1:0]    clr;
  logic                sel_enabled;
  logic [IRQ_ID_W-1:0] enc_idx;
  logic                enc_valid;

  assign irq_edge    = irq & ~irq_q;
  assign enabled     = pending_q & mask_q;
  assign sel         = ONE << irq_id_q;
  assign sel_enabled = |(sel & enabled);

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .req_i   (enabled),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    epc_d    = epc_q;
    ld_d     = 1'b0;
    end_d    = 1'b0;
    clr      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          irq_id_d = enc_idx;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A line masked while draining falls back without a pulse; pending stays.
        if (!sel_enabled) begin
          state_d = ST_IDLE;
        end else if (safe_point) begin
          ld_d    = 1'b1;
          epc_d   = epc_src;
          clr     = sel;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eret_ex) begin
          end_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh edge in the take cycle wins over the clear.
    pending_d = (pending_q & ~clr) | irq_edge;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      irq_id_q  <= '0;
      epc_q     <= '0;
      ld_q      <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq;
      pending_q <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
      irq_id_q  <= irq_id_d;
      epc_q     <= epc_d;
      ld_q      <= ld_d;
      end_q     <= end_d;
    end
  end

  assign LD_INTS    = ld_q;
  assign INTS_end   = end_q;
  assign EPC        = epc_q;
  assign irq_id     = irq_id_q;
  assign in_service = (state_q == ST_SERVICE);
  assign INTS_PC    = vec_addr(VEC_BASE, VEC_STRIDE, irq_id_q);

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the interrupt rules.
module tb_int_sequencer;

  localparam int          N  = 4;
  localparam logic [31:0] VB = 32'h0000_0800;
  localparam logic [31:0] VS = 32'h0000_0010;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_HANDLER = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          safe_point;
  logic [31:0]   epc_src;
  logic          eret_ex;
  logic          LD_INTS;
  logic [31:0]   INTS_PC;
  logic          INTS_end;
  logic [31:0]   EPC;
  logic [2:0]    irq_id;
  logic          in_service;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [N-1:0] m_pend, m_mask, m_prev;
  int         m_phase;
  int         m_line;
  logic [31:0] m_epc;
  bit         m_ld, m_end;

  int_sequencer #(.N_IRQ(N), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .safe_point (safe_point),
    .epc_src    (epc_src),
    .eret_ex    (eret_ex),
    .LD_INTS    (LD_INTS),
    .INTS_PC    (INTS_PC),
    .INTS_end   (INTS_end),
    .EPC        (EPC),
    .irq_id     (irq_id),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_mask  = '0;
    m_prev  = '0;
    m_phase = P_IDLE;
    m_line  = 0;
    m_epc   = '0;
    m_ld    = 0;
    m_end   = 0;
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    bit [N-1:0] rises;
    bit [N-1:0] live;
    rises = irq & ~m_prev;
    live  = m_pend & m_mask;
    m_ld  = 0;
    m_end = 0;
    if (m_phase == P_IDLE) begin
      if (live != 0) begin
        m_line = -1;
        for (int i = 0; i < N; i++) if (live[i] && m_line < 0) m_line = i;
        m_phase = P_WAIT;
      end
    end else if (m_phase == P_WAIT) begin
      if (!live[m_line]) begin
        m_phase = P_IDLE;
      end else if (safe_point) begin
        m_ld  = 1;
        m_epc = epc_src;
        m_pend[m_line] = 0;
        m_phase = P_HANDLER;
      end
    end else begin
      if (eret_ex) begin
        m_end   = 1;
        m_phase = P_IDLE;
      end
    end
    m_pend = m_pend | rises;
    if (mask_we) m_mask = mask_wdata;
    m_prev = irq;
  endtask

  task automatic compare_all();
    check("LD_INTS", 32'(LD_INTS), 32'(m_ld));
    check("INTS_end", 32'(INTS_end), 32'(m_end));
    check("EPC", EPC, m_epc);
    check("irq_id", 32'(irq_id), 32'(m_line));
    check("INTS_PC", INTS_PC, VB + VS * 32'(m_line));
    check("in_service", 32'(in_service), 32'(m_phase == P_HANDLER));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    cycle();
    mask_we    = 1'b0;
  endtask

  task automatic run_until_ld(input int max, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      cycle();
      if (LD_INTS === 1'b1) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic do_eret(input string tag);
    eret_ex = 1'b1;
    cycle();
    eret_ex = 1'b0;
    check(tag, 32'(INTS_end), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    irq        = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    safe_point = 1'b0;
    epc_src    = '0;
    eret_ex    = 1'b0;
    model_reset();
    #2;
    check("reset_LD", 32'(LD_INTS), 32'd0);
    check("reset_PC", INTS_PC, 32'h0000_0800);
    check("reset_insvc", 32'(in_service), 32'd0);
    check("reset_EPC", EPC, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic entry and return on line 2
    safe_point = 1'b1;
    epc_src    = 32'h0000_0040;
    write_mask(4'b1111);
    irq = 4'b0100;
    cycle();
    cycle();
    check("basic_no_early_ld", 32'(LD_INTS), 32'd0);
    cycle();
    check("basic_ld", 32'(LD_INTS), 32'd1);
    check("basic_pc", INTS_PC, 32'h0000_0820);
    check("basic_epc", EPC, 32'h0000_0040);
    check("basic_id", 32'(irq_id), 32'd2);
    check("basic_insvc", 32'(in_service), 32'd1);
    cycle();
    check("basic_ld_single", 32'(LD_INTS), 32'd0);
    irq = '0;
    do_eret("basic_end");
    check("basic_insvc_off", 32'(in_service), 32'd0);
    cycle();
    check("basic_end_single", 32'(INTS_end), 32'd0);

    // Priority: lines 3 and 1 together
    irq = 4'b1010;
    run_until_ld(10, "prio_first_ld");
    check("prio_first_pc", INTS_PC, 32'h0000_0810);
    do_eret("prio_first_end");
    run_until_ld(10, "prio_second_ld");
    check("prio_second_pc", INTS_PC, 32'h0000_0830);
    do_eret("prio_second_end");
    irq = '0;
    cycle();

    // Drain hold while the pipeline is not safe
    safe_point = 1'b0;
    irq = 4'b0001;
    cycle();
    cycle();
    for (int i = 0; i < 10; i++) cycle();
    check("drain_hold_insvc", 32'(in_service), 32'd0);
    safe_point = 1'b1;
    epc_src    = 32'h1234_5678;
    cycle();
    check("drain_release_ld", 32'(LD_INTS), 32'd1);
    check("drain_release_epc", EPC, 32'h1234_5678);
    irq = '0;
    do_eret("drain_end");

    // Mask zero blocks, later unmask takes it
    write_mask(4'b0000);
    irq = 4'b0001;
    for (int i = 0; i < 5; i++) cycle();
    check("masked_no_ld", 32'(LD_INTS), 32'd0);
    irq = '0;
    write_mask(4'b0001);
    run_until_ld(10, "unmask_ld");
    check("unmask_pc", INTS_PC, 32'h0000_0800);
    do_eret("unmask_end");

    // Masking during DRAIN: back to idle, pending kept
    safe_point = 1'b0;
    write_mask(4'b1111);
    irq = 4'b0001;
    cycle();
    cycle();
    irq = '0;
    write_mask(4'b0000);
    safe_point = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("mask_drain_no_ld", 32'(LD_INTS), 32'd0);
    write_mask(4'b1111);
    run_until_ld(10, "mask_drain_retained_ld");
    check("mask_drain_id", 32'(irq_id), 32'd0);
    do_eret("mask_drain_end");

    // Edge coincident with the take cycle
    irq = 4'b0001;
    cycle();
    irq = '0;
    cycle();
    irq = 4'b0001;
    cycle();
    check("coinc_ld", 32'(LD_INTS), 32'd1);
    irq = '0;
    do_eret("coinc_end");
    run_until_ld(10, "coinc_second_ld");
    check("coinc_second_id", 32'(irq_id), 32'd0);
    do_eret("coinc_second_end");

    // Reset in the middle of a service
    irq = 4'b0100;
    run_until_ld(10, "rst_take_ld");
    irq = '0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_insvc", 32'(in_service), 32'd0);
    check("rst_async_pc", INTS_PC, 32'h0000_0800);
    check("rst_async_id", 32'(irq_id), 32'd0);
    check("rst_async_epc", EPC, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    eret_ex = 1'b1;
    cycle();
    eret_ex = 1'b0;
    check("rst_no_end", 32'(INTS_end), 32'd0);

    // Random traffic against the model
    write_mask(4'b1111);
    for (int i = 0; i < 800; i++) begin
      irq        = irq ^ N'($urandom_range(0, 15) & (($urandom_range(0, 3) == 0) ? 15 : 0));
      mask_we    = ($urandom_range(0, 19) == 0);
      mask_wdata = N'($urandom);
      safe_point = ($urandom_range(0, 9) < 7);
      eret_ex    = ($urandom_range(0, 4) == 0);
      epc_src    = $urandom;
      cycle();
    end
    mask_we = 1'b0;
    eret_ex = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
